// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative multiply/divide unit for the Execute stage.
// Runs a WIDTH-step shift-add multiply or restoring divide and holds the
// architectural HI/LO registers, with mthi/mtlo writes accepted while idle.
//
// Build option: define MULDIV_DIV_EN to build the divider (ops 10/11).
// Without it, divide starts are ignored and only multiply is built.
//
// Ports:
//   clk      pipeline clock, rising edge
//   rst      synchronous active-high reset
//   start_e  muldiv op present in Execute
//   op_e     00 multu, 01 mult, 10 divu, 11 div
//   src_a_e  rs operand (also the mthi/mtlo data)
//   src_b_e  rt operand
//   mthi_e   write src_a_e to HI
//   mtlo_e   write src_a_e to LO
//   hi, lo   architectural HI/LO
//   busy     operation in progress
//   done     one-cycle pulse when HI/LO take a result
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_e,
  input  logic [1:0]       op_e,
  input  logic [WIDTH-1:0] src_a_e,
  input  logic [WIDTH-1:0] src_b_e,
  input  logic             mthi_e,
  input  logic             mtlo_e,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state, next_state;
  logic [CW-1:0]    count;
  logic [AW-1:0]    acc;      // product, or {remainder, dividend/quotient}
  logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
  logic             sign_a, sign_b;
  logic             start_ok;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    acc_step;
  logic [AW-1:0]    prod;
  logic [WIDTH-1:0] res_hi, res_lo;

`ifdef MULDIV_DIV_EN
  logic             op_div;
  logic             div_zero;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;

  assign start_ok = start_e;
`else
  assign start_ok = start_e & ~op_e[1];
`endif

  // Operand magnitudes and signs; only signed ops (op_e[0]) look at sign bits.
  always_comb begin
    a_neg = op_e[0] & src_a_e[WIDTH-1];
    b_neg = op_e[0] & src_b_e[WIDTH-1];
    a_mag = a_neg ? -src_a_e : src_a_e;
    b_mag = b_neg ? -src_b_e : src_b_e;
  end

  // One iteration of the selected datapath.
  always_comb begin
    mul_sum  = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    acc_step = {mul_sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    // Shift remainder left with next dividend bit, trial-subtract divisor.
    div_shift = acc[AW-1:WIDTH-1];
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    if (op_div) begin
      if (div_diff[WIDTH+1])
        acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
`endif
  end

  // Sign correction applied in FIX.
  always_comb begin
    prod   = (sign_a ^ sign_b) ? -acc : acc;
    res_hi = prod[AW-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (op_div) begin
      // Divide by zero keeps the all-ones quotient unnegated.
      res_lo = ((sign_a ^ sign_b) && !div_zero) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      res_hi = sign_a ? -acc[AW-1:WIDTH] : acc[AW-1:WIDTH];
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_ok) next_state = RUN;
      RUN:     if (count == CW'(WIDTH - 1)) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath, HI/LO and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
`ifdef MULDIV_DIV_EN
      op_div   <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      busy <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (start_ok) begin
            count  <= '0;
            sign_a <= a_neg;
            sign_b <= b_neg;
`ifdef MULDIV_DIV_EN
            op_div   <= op_e[1];
            div_zero <= (src_b_e == '0);
            if (op_e[1]) begin
              acc  <= {{WIDTH{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{WIDTH{1'b0}}, b_mag};
              opnd <= a_mag;
            end
`else
            acc  <= {{WIDTH{1'b0}}, b_mag};
            opnd <= a_mag;
`endif
          end else begin
            // Accepted start has priority; mt writes only land when no op starts.
            if (mthi_e) hi <= src_a_e;
            if (mtlo_e) lo <= src_a_e;
          end
        end
        RUN: begin
          acc   <= acc_step;
          count <= count + CW'(1);
        end
        FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed, table-driven bench for muldiv_sequencer.
// Checks latency, busy window, done pulse, HI/LO results and HI/LO hold,
// plus mthi/mtlo, start priority, ignored mid-run start and mid-run reset.
module tb_muldiv_sequencer;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_e;
  logic [1:0]   op_e;
  logic [W-1:0] src_a_e;
  logic [W-1:0] src_b_e;
  logic         mthi_e;
  logic         mtlo_e;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  // Bench model of architectural HI/LO.
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_e (start_e),
    .op_e    (op_e),
    .src_a_e (src_a_e),
    .src_b_e (src_b_e),
    .mthi_e  (mthi_e),
    .mtlo_e  (mtlo_e),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue one op; optionally inject a second start (plus mthi) after edge E<inj>,
  // optionally assert mtlo together with the start.
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input int inj, input logic mt);
    int   cycles;
    int   busy_cycles;
    logic held;
    held    = 1'b1;
    op_e    = op;
    src_a_e = a;
    src_b_e = b;
    start_e = 1'b1;
    mtlo_e  = mt;
    tick;
    start_e = 1'b0;
    mtlo_e  = 1'b0;
    cycles      = 0;
    busy_cycles = 0;
    while (!done && cycles < 100) begin
      if (busy) busy_cycles++;
      if (hi !== m_hi || lo !== m_lo) held = 1'b0;
      if (cycles == inj) begin
        start_e = 1'b1;
        op_e    = 2'b01;
        src_a_e = 32'd7;
        src_b_e = 32'd9;
        mthi_e  = 1'b1;
      end else begin
        start_e = 1'b0;
        mthi_e  = 1'b0;
      end
      tick;
      cycles++;
    end
    start_e = 1'b0;
    mthi_e  = 1'b0;
    chk({name, " latency"}, W'(cycles), 32'd33);
    chk({name, " busy_cycles"}, W'(busy_cycles), 32'd33);
    chk({name, " busy_after"}, W'(busy), 32'd0);
    chk({name, " hold"}, W'(held), 32'd1);
    chk({name, " hi"}, hi, exp_hi);
    chk({name, " lo"}, lo, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
    tick;
    chk({name, " done_pulse"}, W'(done), 32'd0);
  endtask

  initial begin
    int   seen;
    rst     = 1'b1;
    start_e = 1'b0;
    op_e    = 2'b00;
    src_a_e = '0;
    src_b_e = '0;
    mthi_e  = 1'b0;
    mtlo_e  = 1'b0;

    vecs.push_back('{"multu_3x5",   2'b00, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F});
    vecs.push_back('{"mult_m2x3",   2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA});
    vecs.push_back('{"multu_max",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{"mult_minsq",  2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    vecs.push_back('{"mult_7xm1",   2'b01, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9});
    vecs.push_back('{"multu_x16",   2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780});
`ifdef MULDIV_DIV_EN
    vecs.push_back('{"div_m7d2",    2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"divu_7d0",    2'b10, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF});
    vecs.push_back('{"divu_100d7",  2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E});
    vecs.push_back('{"div_7dm2",    2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
    vecs.push_back('{"div_m7d0",    2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF});
`endif

    repeat (3) tick;
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset busy", W'(busy), 32'h0);
    chk("reset done", W'(done), 32'h0);
    rst = 1'b0;
    tick;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, -1, 1'b0);

`ifndef MULDIV_DIV_EN
    // Divide op without the divider: ignored entirely.
    op_e    = 2'b11;
    src_a_e = 32'h00000064;
    src_b_e = 32'h00000007;
    start_e = 1'b1;
    tick;
    start_e = 1'b0;
    chk("nodiv busy", W'(busy), 32'h0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy || done) seen = 1;
      tick;
    end
    chk("nodiv quiet", W'(seen), 32'h0);
    chk("nodiv hi", hi, m_hi);
    chk("nodiv lo", lo, m_lo);
`endif

    // mthi then mtlo, then both together.
    src_a_e = 32'h12345678;
    mthi_e  = 1'b1;
    tick;
    mthi_e  = 1'b0;
    chk("mthi hi", hi, 32'h12345678);
    src_a_e = 32'h9ABCDEF0;
    mtlo_e  = 1'b1;
    tick;
    mtlo_e  = 1'b0;
    chk("mtlo lo", lo, 32'h9ABCDEF0);
    chk("mtlo hi_kept", hi, 32'h12345678);
    src_a_e = 32'h55AA33CC;
    mthi_e  = 1'b1;
    mtlo_e  = 1'b1;
    tick;
    mthi_e  = 1'b0;
    mtlo_e  = 1'b0;
    chk("mtboth hi", hi, 32'h55AA33CC);
    chk("mtboth lo", lo, 32'h55AA33CC);
    m_hi = 32'h55AA33CC;
    m_lo = 32'h55AA33CC;

    // Second start (with mthi) at E5 is ignored.
    run_op("multu_inj", 2'b00, 32'd3, 32'd5, 32'h0, 32'h0000000F, 4, 1'b0);

    // mtlo together with start: start wins.
    src_a_e = 32'hDEADBEEF;
    mtlo_e  = 1'b1;
    tick;
    mtlo_e  = 1'b0;
    chk("mtlo_pre lo", lo, 32'hDEADBEEF);
    m_lo = 32'hDEADBEEF;
    run_op("multu_mtlo", 2'b00, 32'd3, 32'd5, 32'h0, 32'h0000000F, -1, 1'b1);

    // Leave non-zero HI/LO so the mid-run reset check means something.
    run_op("mult_pre_rst", 2'b01, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, -1, 1'b0);

    // Reset at E10 during a mult.
    op_e    = 2'b01;
    src_a_e = 32'd3;
    src_b_e = 32'd5;
    start_e = 1'b1;
    tick;
    start_e = 1'b0;
    repeat (9) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst busy", W'(busy), 32'h0);
    chk("midrst hi", hi, 32'h0);
    chk("midrst lo", lo, 32'h0);
    chk("midrst done", W'(done), 32'h0);
    m_hi = '0;
    m_lo = '0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) seen = 1;
      tick;
    end
    chk("midrst quiet", W'(seen), 32'h0);
    run_op("multu_2x2", 2'b00, 32'd2, 32'd2, 32'h0, 32'h00000004, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
